// File: rtl/tpcd_round_scheduler.sv
// tpcd_round_scheduler
// Shares one TPCD dart-scoring engine between N_PLAYERS requesters.
// A round runs as follows:
//   1. Round-robin arbitration picks the next requesting player.
//   2. The 16-entry local board image is replayed into the engine.
//   3. The granted player's throws are forwarded to the engine.
//   4. The engine result is captured and added to that player's
//      saturating running total.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   brd_wr/addr/data  board image write (honoured in IDLE/ARB only)
//   req, gnt        per-player round request (level) / one-hot grant
//   thr_*           throw stream from the granted player; thr_ready in STREAM
//   eng_in_*        board-load (valid_1) and throw (valid_2) engine streams
//   eng_out_*       engine result strobe and round sum
//   tot_clr         clear all running totals (honoured in IDLE/ARB only)
//   res_*           one-cycle round result: player, sum, new total, error
//   busy            high whenever not IDLE
// Every output is driven straight from a flop.

module tpcd_round_scheduler #(
  parameter int N_PLAYERS = 4,
  parameter int PW        = 2,
  parameter int TOT_W     = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brd_wr,
  input  logic [3:0]           brd_addr,
  input  logic [2:0]           brd_data,
  input  logic [N_PLAYERS-1:0] req,
  output logic [N_PLAYERS-1:0] gnt,
  input  logic                 thr_valid,
  input  logic                 thr_last,
  input  logic [3:0]           thr_dart,
  input  logic [2:0]           thr_rot,
  input  logic                 thr_ccw,
  output logic                 thr_ready,
  output logic                 eng_in_valid_1,
  output logic [2:0]           eng_in_score,
  output logic                 eng_in_valid_2,
  output logic [3:0]           eng_in_dart,
  output logic [2:0]           eng_in_rotation,
  output logic                 eng_rotate_flag,
  input  logic                 eng_out_valid,
  input  logic [6:0]           eng_out_sum,
  input  logic                 tot_clr,
  output logic                 res_valid,
  output logic [PW-1:0]        res_player,
  output logic [6:0]           res_sum,
  output logic [TOT_W-1:0]     res_total,
  output logic                 res_err,
  output logic                 busy
);

  // One shared counter serves the load beat, timeout and gap phases.
  localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_STREAM, S_WAIT_RES, S_RESULT, S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          player_q, player_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic                   seen_q, seen_d;   // at least one throw this round
  logic                   err_q, err_d;     // sticky round error
  logic [2:0]             board_q [16];
  logic [2:0]             board_d [16];
  logic [TOT_W-1:0]       tot_q [N_PLAYERS];
  logic [TOT_W-1:0]       tot_d [N_PLAYERS];

  logic [N_PLAYERS-1:0]   gnt_q, gnt_d;
  logic                   thr_ready_q, thr_ready_d;
  logic                   v1_q, v1_d;
  logic [2:0]             score_q, score_d;
  logic                   v2_q, v2_d;
  logic [3:0]             dart_q, dart_d;
  logic [2:0]             rot_q, rot_d;
  logic                   ccw_q, ccw_d;
  logic                   res_valid_q, res_valid_d;
  logic [PW-1:0]          res_player_q, res_player_d;
  logic [6:0]             res_sum_q, res_sum_d;
  logic [TOT_W-1:0]       res_total_q, res_total_d;
  logic                   res_err_q, res_err_d;
  logic                   busy_q, busy_d;

  // Round-robin pick: first requester at or after the pointer.
  logic [PW-1:0]          pick;
  logic [PW-1:0]          idx;
  logic                   found;

  // NOTE: every combinational output gets a default before any branch so
  // that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    pick  = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      idx = rr_q + PW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Result formed on the WAIT_RES exit edge so res_valid lines up with RESULT.
  // A gap still yields an engine sum, which is reported and accumulated;
  // only a timeout forces the sum to zero.
  logic                   cfg_win;
  logic [6:0]             fin_sum;
  logic                   fin_err;
  logic [TOT_W:0]         tot_ext;
  logic [TOT_W-1:0]       new_total;

  assign cfg_win   = (state_q == S_IDLE) || (state_q == S_ARB);
  assign fin_sum   = eng_out_valid ? eng_out_sum : 7'd0;
  assign fin_err   = eng_out_valid ? err_q : 1'b1;
  assign tot_ext   = {1'b0, tot_q[player_q]} + (TOT_W+1)'(fin_sum);
  assign new_total = tot_ext[TOT_W] ? {TOT_W{1'b1}} : tot_ext[TOT_W-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    player_d     = player_q;
    rr_d         = rr_q;
    seen_d       = seen_q;
    err_d        = err_q;
    board_d      = board_q;
    tot_d        = tot_q;
    v1_d         = 1'b0;
    score_d      = score_q;
    v2_d         = 1'b0;
    dart_d       = dart_q;
    rot_d        = rot_q;
    ccw_d        = ccw_q;
    res_valid_d  = 1'b0;
    res_player_d = res_player_q;
    res_sum_d    = res_sum_q;
    res_total_d  = res_total_q;
    res_err_d    = res_err_q;

    if (brd_wr && cfg_win) board_d[brd_addr] = brd_data;

    case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (|req) begin
          player_d = pick;
          rr_d     = pick + PW'(1);
          state_d  = S_LOAD;
          cnt_d    = '0;
          seen_d   = 1'b0;
          err_d    = 1'b0;
          v1_d     = 1'b1;
          score_d  = board_q[0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(15)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          v1_d    = 1'b1;
          score_d = board_q[cnt_q[3:0] + 4'd1];
        end
      end
      S_STREAM: begin
        if (thr_valid) begin
          v2_d   = 1'b1;
          dart_d = thr_dart;
          rot_d  = thr_rot;
          ccw_d  = thr_ccw;
          seen_d = 1'b1;
          if (thr_last) begin
            state_d = S_WAIT_RES;
            cnt_d   = '0;
          end
        end else if (seen_q) begin
          // Stream broke mid-round: close it as if the last throw arrived.
          err_d   = 1'b1;
          state_d = S_WAIT_RES;
          cnt_d   = '0;
        end
      end
      S_WAIT_RES: begin
        if (eng_out_valid || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d        = S_RESULT;
          res_valid_d    = 1'b1;
          res_player_d   = player_q;
          res_sum_d      = fin_sum;
          res_err_d      = fin_err;
          res_total_d    = new_total;
          tot_d[player_q] = new_total;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESULT: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == CW'(1)) state_d = S_ARB;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Placed after the result update so a clear always wins.
    if (tot_clr && cfg_win) begin
      for (int i = 0; i < N_PLAYERS; i++) tot_d[i] = '0;
    end

    gnt_d = '0;
    if (state_d == S_LOAD || state_d == S_STREAM) gnt_d[player_d] = 1'b1;
    thr_ready_d = (state_d == S_STREAM);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      player_q     <= '0;
      rr_q         <= '0;
      seen_q       <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the board image and totals are small register arrays with
      // defined post-reset contents, so they are reset like any other flop.
      for (int i = 0; i < 16; i++)        board_q[i] <= '0;
      for (int i = 0; i < N_PLAYERS; i++) tot_q[i]   <= '0;
      gnt_q        <= '0;
      thr_ready_q  <= 1'b0;
      v1_q         <= 1'b0;
      score_q      <= '0;
      v2_q         <= 1'b0;
      dart_q       <= '0;
      rot_q        <= '0;
      ccw_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_player_q <= '0;
      res_sum_q    <= '0;
      res_total_q  <= '0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      player_q     <= player_d;
      rr_q         <= rr_d;
      seen_q       <= seen_d;
      err_q        <= err_d;
      board_q      <= board_d;
      tot_q        <= tot_d;
      gnt_q        <= gnt_d;
      thr_ready_q  <= thr_ready_d;
      v1_q         <= v1_d;
      score_q      <= score_d;
      v2_q         <= v2_d;
      dart_q       <= dart_d;
      rot_q        <= rot_d;
      ccw_q        <= ccw_d;
      res_valid_q  <= res_valid_d;
      res_player_q <= res_player_d;
      res_sum_q    <= res_sum_d;
      res_total_q  <= res_total_d;
      res_err_q    <= res_err_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt             = gnt_q;
  assign thr_ready       = thr_ready_q;
  assign eng_in_valid_1  = v1_q;
  assign eng_in_score    = score_q;
  assign eng_in_valid_2  = v2_q;
  assign eng_in_dart     = dart_q;
  assign eng_in_rotation = rot_q;
  assign eng_rotate_flag = ccw_q;
  assign res_valid       = res_valid_q;
  assign res_player      = res_player_q;
  assign res_sum         = res_sum_q;
  assign res_total       = res_total_q;
  assign res_err         = res_err_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_tpcd_round_scheduler.sv
// Scoreboard bench for tpcd_round_scheduler. Round tasks predict grants,
// board replays, throw forwarding and results from a simple player-level
// model and queue them; independent monitors compare DUT outputs on strobes.

module tb_tpcd_round_scheduler;
  localparam int N       = 4;
  localparam int PW      = 2;
  localparam int TOT_W   = 10;
  localparam int TIMEOUT = 64;
  localparam int TMAX    = (1 << TOT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             brd_wr = 1'b0;
  logic [3:0]       brd_addr = '0;
  logic [2:0]       brd_data = '0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     gnt;
  logic             thr_valid = 1'b0, thr_last = 1'b0, thr_ccw = 1'b0;
  logic [3:0]       thr_dart = '0;
  logic [2:0]       thr_rot = '0;
  logic             thr_ready;
  logic             eng_in_valid_1, eng_in_valid_2, eng_rotate_flag;
  logic [2:0]       eng_in_score, eng_in_rotation;
  logic [3:0]       eng_in_dart;
  logic             eng_out_valid = 1'b0;
  logic [6:0]       eng_out_sum = '0;
  logic             tot_clr = 1'b0;
  logic             res_valid, res_err, busy;
  logic [PW-1:0]    res_player;
  logic [6:0]       res_sum;
  logic [TOT_W-1:0] res_total;

  tpcd_round_scheduler #(.N_PLAYERS(N), .PW(PW), .TOT_W(TOT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .brd_wr(brd_wr), .brd_addr(brd_addr), .brd_data(brd_data),
    .req(req), .gnt(gnt), .thr_valid(thr_valid), .thr_last(thr_last),
    .thr_dart(thr_dart), .thr_rot(thr_rot), .thr_ccw(thr_ccw), .thr_ready(thr_ready),
    .eng_in_valid_1(eng_in_valid_1), .eng_in_score(eng_in_score),
    .eng_in_valid_2(eng_in_valid_2), .eng_in_dart(eng_in_dart),
    .eng_in_rotation(eng_in_rotation), .eng_rotate_flag(eng_rotate_flag),
    .eng_out_valid(eng_out_valid), .eng_out_sum(eng_out_sum), .tot_clr(tot_clr),
    .res_valid(res_valid), .res_player(res_player), .res_sum(res_sum),
    .res_total(res_total), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: board contents, totals and round-robin pointer.
  int m_board [16];
  int m_tot [N];
  int m_rr = 0;

  typedef struct {int player; int sum; int total; int err;} res_t;
  res_t exp_res[$];
  int   exp_score[$];
  int   exp_thr[$];
  int   exp_gnt[$];

  function automatic int model_pick(input logic [N-1:0] rq);
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (rq[c]) begin
        m_rr = (c + 1) % N;
        return c;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_board[i] = 0;
    for (int i = 0; i < N; i++)  m_tot[i] = 0;
    m_rr = 0;
  endfunction

  // ---------------- monitors ----------------
  logic [N-1:0] gnt_prev = '0;

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (exp_res.size() == 0) check("res_unexpected", 32'(res_valid), 0);
      else begin
        res_t r;
        r = exp_res.pop_front();
        check("res_player", 32'(res_player), r.player);
        check("res_sum",    32'(res_sum),    r.sum);
        check("res_total",  32'(res_total),  r.total);
        check("res_err",    32'(res_err),    r.err);
      end
    end
    if (eng_in_valid_1 === 1'b1) begin
      if (exp_score.size() == 0) check("load_unexpected", 32'(eng_in_valid_1), 0);
      else check("load_score", 32'(eng_in_score), exp_score.pop_front());
    end
    if (eng_in_valid_2 === 1'b1) begin
      if (exp_thr.size() == 0) check("throw_unexpected", 32'(eng_in_valid_2), 0);
      else check("throw_fwd", 32'({eng_in_dart, eng_in_rotation, eng_rotate_flag}),
                 exp_thr.pop_front());
    end
    if (gnt !== 'x && gnt != 0 && gnt_prev == 0) begin
      if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
      else check("gnt_onehot", 32'(gnt), 1 << exp_gnt.pop_front());
    end
    gnt_prev = (gnt === 'x) ? '0 : gnt;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy == 1'b0) return;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic idle_op(input bit wr, input int a, input int d, input bit clr);
    @(posedge clk); #1;
    brd_wr = wr; brd_addr = 4'(a); brd_data = 3'(d); tot_clr = clr;
    @(posedge clk); #1;
    brd_wr = 1'b0; tot_clr = 1'b0;
    if (wr) m_board[a] = d;
    if (clr) for (int i = 0; i < N; i++) m_tot[i] = 0;
  endtask

  task automatic do_round(input logic [N-1:0] rq, input bit hold, input int nthr,
                          input bit gap, input int esum, input bit silent,
                          input bit spur, input bit poke);
    int p, s, lat;
    int thr[$];
    bit ok;
    res_t r;
    p = model_pick(rq);
    exp_gnt.push_back(p);
    for (int i = 0; i < 16; i++) exp_score.push_back(m_board[i]);
    for (int k = 0; k < nthr; k++) begin
      int t = int'($urandom_range(0, 255));
      thr.push_back(t);
      exp_thr.push_back(t);
    end
    s = silent ? 0 : esum;
    r.player = p;
    r.sum    = s;
    r.total  = (m_tot[p] + s > TMAX) ? TMAX : m_tot[p] + s;
    r.err    = (gap || silent) ? 1 : 0;
    m_tot[p] = r.total;
    exp_res.push_back(r);

    @(posedge clk); #1 req = rq;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (gnt != 0) ok = 1'b1;
    end
    if (!ok) begin check("gnt_wait_timeout", 32'(gnt), 1 << p); return; end
    if (!hold) begin @(posedge clk); #1 req = '0; end
    if (spur) begin
      // Engine strobe outside WAIT_RES must be ignored.
      @(posedge clk); #1 eng_out_valid = 1'b1; eng_out_sum = 7'h55;
      @(posedge clk); #1 eng_out_valid = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (thr_ready) ok = 1'b1;
    end
    if (!ok) begin check("stream_wait_timeout", 32'(thr_ready), 1); return; end
    if (poke) begin
      // Board write and total clear while busy must both be dropped.
      @(posedge clk); #1
      brd_wr = 1'b1; brd_addr = 4'($urandom_range(0, 15));
      brd_data = 3'($urandom_range(0, 7)); tot_clr = 1'b1;
      @(posedge clk); #1 brd_wr = 1'b0; tot_clr = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    for (int k = 0; k < nthr; k++) begin
      @(posedge clk); #1;
      thr_valid = 1'b1;
      {thr_dart, thr_rot, thr_ccw} = 8'(thr[k]);
      thr_last = (k == nthr - 1) && !gap;
    end
    @(posedge clk); #1 thr_valid = 1'b0; thr_last = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!thr_ready) ok = 1'b1;
    end
    if (!ok) begin check("wait_res_entry_timeout", 32'(thr_ready), 0); return; end
    if (!silent) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      @(posedge clk); #1 eng_out_valid = 1'b1; eng_out_sum = 7'(esum);
      @(posedge clk); #1 eng_out_valid = 1'b0;
    end
    lat = -1;
    for (int i = 1; i <= 200 && lat < 0; i++) begin
      @(negedge clk);
      if (res_valid) lat = i;
    end
    if (lat < 0) check("res_wait_timeout", 32'(res_valid), 1);
    else if (silent) check("timeout_latency", 32'(lat), TIMEOUT);
    check("throws_drained", 32'(exp_thr.size()), 0);
    check("load_drained", 32'(exp_score.size()), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_thr_ready", 32'(thr_ready), 0);
    check("rst_v1", 32'(eng_in_valid_1), 0);
    check("rst_v2", 32'(eng_in_valid_2), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_total", 32'(res_total), 0);

    // Board all 2, single player, three throws, engine returns 6.
    for (int a = 0; a < 16; a++) idle_op(1'b1, a, 2, a == 5);
    do_round(4'b0001, 1'b0, 3, 1'b0, 6, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Distinct board pattern, then round robin with all requesters held.
    for (int a = 0; a < 16; a++) idle_op(1'b1, a, (a * 3 + 1) % 8, 1'b0);
    for (int k = 0; k < 8; k++)
      do_round(4'b1111, 1'b1, 1 + k % 3, 1'b0, int'($urandom_range(0, 127)), 1'b0, 1'b0, 1'b0);
    do_round(4'b1111, 1'b1, 2, 1'b0, 9, 1'b0, 1'b0, 1'b0);
    do_round(4'b1010, 1'b1, 2, 1'b0, 10, 1'b0, 1'b0, 1'b0);
    do_round(4'b1010, 1'b0, 2, 1'b0, 11, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Silent engine: timeout error, sum 0, total unchanged.
    do_round(4'b0010, 1'b0, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Saturation for player 2, then clear in IDLE.
    idle_op(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      do_round(4'b0100, 1'b0, 1, 1'b0, 100, 1'b0, 1'b0, 1'b0);
      wait_idle();
    end
    idle_op(1'b1, 7, 5, 1'b1);
    do_round(4'b0100, 1'b0, 2, 1'b0, 37, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Gap after two throws: error, engine sum still accumulated.
    do_round(4'b1000, 1'b0, 2, 1'b1, 21, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Reset in the 7th LOAD cycle.
    begin
      bit ok;
      exp_gnt.push_back(model_pick(4'b0001));
      for (int i = 0; i < 16; i++) exp_score.push_back(m_board[i]);
      @(posedge clk); #1 req = 4'b0001;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (gnt != 0) ok = 1'b1;
      end
      check("rst_test_gnt_seen", 32'(ok), 1);
      @(posedge clk); #1 req = '0;
      repeat (4) @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_score.delete();
      model_reset();
      @(negedge clk);
      check("midrst_v1", 32'(eng_in_valid_1), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_gnt", 32'(gnt), 0);
      check("midrst_res_valid", 32'(res_valid), 0);
      repeat (10) @(negedge clk);
      check("midrst_quiet", 32'(busy), 0);
    end
    for (int a = 0; a < 16; a++) idle_op(1'b1, a, 7 - (a % 8), 1'b0);
    do_round(4'b0110, 1'b0, 3, 1'b0, 44, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Randomised rounds.
    for (int k = 0; k < 16; k++) begin
      idle_op(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0);
      do_round(4'($urandom_range(1, 15)), 1'b0, int'($urandom_range(1, 5)),
               $urandom_range(0, 4) == 0, int'($urandom_range(0, 127)),
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("results_drained", 32'(exp_res.size()), 0);
    check("grants_drained", 32'(exp_gnt.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
